// File: rtl/decoder_scan_gen.sv
// decoder_scan_gen: registered binary-to-one-hot / thermometer decoder with an
// autonomous scan mode that walks a one-hot pointer at a programmable dwell rate.
//
// Ports:
//   clock      - single clock, all state updates on the rising edge
//   reset      - synchronous active-high reset
//   in_valid   - command strobe, a command is taken every cycle it is high
//   in_sel     - binary select, or start pointer for a scan command
//   in_mode    - 0 ONEHOT, 1 THERM, 2 SCAN, 3 HOLD
//   in_en      - output enable for the command
//   in_dwell   - scan step period minus one, in cycles
//   out_dec    - registered decoded outputs
//   out_valid  - one-cycle pulse when out_dec is updated by a command or a step
//   busy       - high while a scan is running
//   err        - one-cycle pulse for a command whose in_sel is out of range
module decoder_scan_gen #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [1:0]         in_mode,
  input  logic               in_en,
  input  logic [DWELL_W-1:0] in_dwell,
  output logic [OUT_W-1:0]   out_dec,
  output logic               out_valid,
  output logic               busy,
  output logic               err
);

  localparam logic [1:0] MODE_ONEHOT = 2'd0;
  localparam logic [1:0] MODE_THERM  = 2'd1;
  localparam logic [1:0] MODE_SCAN   = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0]   dwell_rld_q, dwell_rld_d;
  logic [OUT_W-1:0]     out_dec_q, out_dec_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 sel_oob;
  logic [SEL_W-1:0]     ptr_next;

  // One-hot of a select value, truncated to OUT_W bits
  function automatic logic [OUT_W-1:0] onehot_of(input logic [SEL_W-1:0] s);
    onehot_of = OUT_W'(1) << s;
  endfunction

  // Thermometer code: bits [s:0] set
  function automatic logic [OUT_W-1:0] therm_of(input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      r[i] = (i <= 32'(s));
    end
    therm_of = r;
  endfunction

  assign sel_oob  = (32'(in_sel) >= OUT_W);
  assign ptr_next = (32'(ptr_q) == OUT_W - 1) ? '0 : ptr_q + SEL_W'(1);

  // Next-state and output logic; an accepted command always overrides a scan step
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dwell_cnt_d = dwell_cnt_q;
    dwell_rld_d = dwell_rld_q;
    out_dec_d   = out_dec_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;

    if (in_valid) begin
      out_valid_d = 1'b1;
      state_d     = ST_STATIC;
      if (in_mode == MODE_HOLD) begin
        // Output and pointer frozen; a running scan simply stops
      end else if (sel_oob) begin
        out_dec_d = '0;
        err_d     = 1'b1;
      end else begin
        case (in_mode)
          MODE_ONEHOT: out_dec_d = in_en ? onehot_of(in_sel) : '0;
          MODE_THERM:  out_dec_d = in_en ? therm_of(in_sel) : '0;
          MODE_SCAN: begin
            if (in_en) begin
              state_d     = ST_SCAN;
              ptr_d       = in_sel;
              dwell_cnt_d = in_dwell;
              dwell_rld_d = in_dwell;
              out_dec_d   = onehot_of(in_sel);
            end else begin
              out_dec_d = '0;
            end
          end
          default: ;
        endcase
      end
    end else if (state_q == ST_SCAN) begin
      if (dwell_cnt_q != '0) begin
        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
      end else begin
        ptr_d       = ptr_next;
        out_dec_d   = onehot_of(ptr_next);
        dwell_cnt_d = dwell_rld_q;
        out_valid_d = 1'b1;
      end
    end

    busy_d = (state_d == ST_SCAN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      dwell_cnt_q <= '0;
      dwell_rld_q <= '0;
      out_dec_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_rld_q <= dwell_rld_d;
      out_dec_q   <= out_dec_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign out_dec   = out_dec_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
